// File: rtl/onchip_ram_dp.sv
// True dual-port byte-lane RAM with two Avalon-MM slave ports and pipelined reads.
// Define ONCHIP_RAM_CLEAR_EN to build the post-reset CLEAR/READY zeroing sequencer.
module onchip_ram_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter     INIT_FILE    = "RAM.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest,
  output logic                    collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  logic                  clearing;
  logic                  wait_req;
  logic                  acc1, acc2, wr1, wr2, rd1, rd2;
  logic                  coll_hit, wr2_eff;
  logic                  w1_en;
  logic [ADDR_WIDTH-1:0] w1_addr;
  logic [NB-1:0]         w1_be;
  logic [DATA_WIDTH-1:0] w1_data;
  logic [1:0]            rd_en;
  logic [1:0][DATA_WIDTH-1:0] q;
  logic [1:0][DATA_WIDTH-1:0] rdata;
  logic [1:0]                 vld;

  assign wait_req       = !clken || clearing;
  assign s1_waitrequest = wait_req;
  assign s2_waitrequest = wait_req;

  assign acc1 = s1_chipselect && (s1_read || s1_write) && !wait_req;
  assign acc2 = s2_chipselect && (s2_read || s2_write) && !wait_req;
  assign wr1  = acc1 && s1_write;
  assign wr2  = acc2 && s2_write;
  // a read issued together with a write on the same port is dropped
  assign rd1  = acc1 && s1_read && !s1_write;
  assign rd2  = acc2 && s2_read && !s2_write;
  assign rd_en = {rd2, rd1};

  // s1 owns the word on a same-address double write; s2 is dropped whole
  assign coll_hit = wr1 && wr2 && (s1_address == s2_address);
  assign wr2_eff  = wr2 && !coll_hit;

`ifdef ONCHIP_RAM_CLEAR_EN
  typedef enum logic {CLEAR, READY} state_t;
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) clr_addr <= clr_addr + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_addr == '1) state_nx = READY;
  end

  assign clearing = (state == CLEAR);
  assign w1_en    = clearing || wr1;
  assign w1_addr  = clearing ? clr_addr : s1_address;
  assign w1_be    = clearing ? '1 : s1_byteenable;
  assign w1_data  = clearing ? '0 : s1_writedata;
`else
  // INIT_FILE names the power-up image loaded by the memory-initialisation flow
  assign clearing = 1'b0;
  assign w1_en    = wr1;
  assign w1_addr  = s1_address;
  assign w1_be    = s1_byteenable;
  assign w1_data  = s1_writedata;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0] lane [DEPTH];

    always_ff @(posedge clk) begin
      if (wr2_eff && s2_byteenable[b]) lane[s2_address] <= s2_writedata[b*8 +: 8];
      if (w1_en && w1_be[b])           lane[w1_addr]    <= w1_data[b*8 +: 8];
    end

    assign q[0][b*8 +: 8] = lane[s1_address];
    assign q[1][b*8 +: 8] = lane[s2_address];
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] rdata_p0;
    logic                  vld_p0;

    // p0: array read captured at the accepting edge (old data on read-during-write)
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_p0   <= 1'b0;
        rdata_p0 <= '0;
      end else begin
        vld_p0 <= rd_en[p];
        if (rd_en[p]) rdata_p0 <= q[p];
      end
    end

    if (READ_LATENCY == 2) begin : g_out_reg
      logic [DATA_WIDTH-1:0] rdata_p1;
      logic                  vld_p1;

      // p1: optional output register, holds last data between valids
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_p1   <= 1'b0;
          rdata_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) rdata_p1 <= rdata_p0;
        end
      end

      assign rdata[p] = rdata_p1;
      assign vld[p]   = vld_p1;
    end else begin : g_direct
      assign rdata[p] = rdata_p0;
      assign vld[p]   = vld_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) collision <= 1'b0;
    else       collision <= coll_hit;
  end

  assign s1_readdata      = rdata[0];
  assign s1_readdatavalid = vld[0];
  assign s2_readdata      = rdata[1];
  assign s2_readdatavalid = vld[1];

endmodule

// File: tb/tb_onchip_ram_dp.sv
// Bench for onchip_ram_dp: directed scenarios plus randomized traffic checked
// against a word-array / read-queue model of the two ports.
module tb_onchip_ram_dp;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int LAT = 2;
  localparam int DEPTH = 1 << AW;
  localparam int NB = DW / 8;
`ifdef ONCHIP_RAM_CLEAR_EN
  localparam bit WAIT_RST = 1'b1;
`else
  localparam bit WAIT_RST = 1'b0;
`endif

  logic clk, reset, clken;
  logic [AW-1:0] s1_address, s2_address;
  logic s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [NB-1:0] s1_byteenable, s2_byteenable;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest, collision;

  onchip_ram_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(LAT), .INIT_FILE("RAM.hex")) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(s2_readdata),
    .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
    .collision(collision)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int due; logic [DW-1:0] data; } rd_t;

  logic [DW-1:0] mem_m [DEPTH];
  rd_t q1[$], q2[$];
  logic exp_vld1, exp_vld2, exp_coll;
  logic [DW-1:0] exp_rd1, exp_rd2;
  bit clearing_m;
  int clr_m, edge_n;
  int n_tests, n_fail;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [NB-1:0] be);
    merge = old;
    for (int b = 0; b < NB; b++) if (be[b]) merge[b*8 +: 8] = d[b*8 +: 8];
  endfunction

  task automatic drive1(input logic cs, rd, wr, input logic [AW-1:0] a, input logic [NB-1:0] be,
                        input logic [DW-1:0] d);
    s1_chipselect = cs; s1_read = rd; s1_write = wr; s1_address = a; s1_byteenable = be; s1_writedata = d;
  endtask

  task automatic drive2(input logic cs, rd, wr, input logic [AW-1:0] a, input logic [NB-1:0] be,
                        input logic [DW-1:0] d);
    s2_chipselect = cs; s2_read = rd; s2_write = wr; s2_address = a; s2_byteenable = be; s2_writedata = d;
  endtask

  task automatic idle();
    drive1(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive2(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Advance one clock edge; the model applies the accepted transfers of that edge.
  task automatic tick();
    logic a1, a2, w1, w2, r1, r2, col;
    logic [DW-1:0] d1, d2;
    rd_t e;
    a1 = s1_chipselect && (s1_read || s1_write) && clken && !clearing_m;
    a2 = s2_chipselect && (s2_read || s2_write) && clken && !clearing_m;
    w1 = a1 && s1_write;
    w2 = a2 && s2_write;
    r1 = a1 && s1_read && !s1_write;
    r2 = a2 && s2_read && !s2_write;
    col = w1 && w2 && (s1_address == s2_address);
    d1 = mem_m[s1_address];
    d2 = mem_m[s2_address];
    @(posedge clk);
    edge_n++;
    if (reset) begin
      q1.delete(); q2.delete();
      exp_vld1 = 1'b0; exp_vld2 = 1'b0; exp_rd1 = '0; exp_rd2 = '0; exp_coll = 1'b0;
`ifdef ONCHIP_RAM_CLEAR_EN
      clearing_m = 1'b1; clr_m = 0;
`endif
    end else begin
      if (clearing_m) begin
        mem_m[clr_m] = '0;
        clr_m++;
        if (clr_m == DEPTH) clearing_m = 1'b0;
      end
      if (w2 && !col) mem_m[s2_address] = merge(mem_m[s2_address], s2_writedata, s2_byteenable);
      if (w1) mem_m[s1_address] = merge(mem_m[s1_address], s1_writedata, s1_byteenable);
      if (r1) q1.push_back('{edge_n + LAT - 1, d1});
      if (r2) q2.push_back('{edge_n + LAT - 1, d2});
      exp_coll = col;
      exp_vld1 = 1'b0;
      if (q1.size() > 0 && q1[0].due == edge_n) begin e = q1.pop_front(); exp_vld1 = 1'b1; exp_rd1 = e.data; end
      exp_vld2 = 1'b0;
      if (q2.size() > 0 && q2[0].due == edge_n) begin e = q2.pop_front(); exp_vld2 = 1'b1; exp_rd2 = e.data; end
    end
    #1;
  endtask

  task automatic test_reset();
    int n;
    idle(); clken = 1'b1; reset = 1'b1;
    tick(); tick();
    n_tests++; if ({s1_readdatavalid, s2_readdatavalid, collision} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b, expected 000", {s1_readdatavalid, s2_readdatavalid, collision}); end
    n_tests++; if (s1_readdata !== '0) begin n_fail++; $display("FAIL reset_rd1: got %h, expected 0", s1_readdata); end
    n_tests++; if (s2_readdata !== '0) begin n_fail++; $display("FAIL reset_rd2: got %h, expected 0", s2_readdata); end
    n_tests++; if ({s1_waitrequest, s2_waitrequest} !== {WAIT_RST, WAIT_RST}) begin
      n_fail++; $display("FAIL reset_wait: got %b, expected %b", {s1_waitrequest, s2_waitrequest}, {WAIT_RST, WAIT_RST}); end
    reset = 1'b0;
`ifdef ONCHIP_RAM_CLEAR_EN
    n = 0;
    while (s1_waitrequest === 1'b1 && n < DEPTH + 8) begin n++; tick(); end
    n_tests++; if (n !== DEPTH) begin n_fail++; $display("FAIL clear_len: got %0d cycles, expected %0d", n, DEPTH); end
    repeat (7) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n = 0;
    while (s1_waitrequest === 1'b1 && n < DEPTH + 8) begin n++; tick(); end
    n_tests++; if (n !== DEPTH) begin n_fail++; $display("FAIL clear_restart: got %0d cycles, expected %0d", n, DEPTH); end
`else
    tick();
    n_tests++; if ({s1_waitrequest, s2_waitrequest} !== 2'b00) begin
      n_fail++; $display("FAIL ready_wait: got %b, expected 00", {s1_waitrequest, s2_waitrequest}); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH / 2; i++) begin
      drive1(1'b1, 1'b0, 1'b1, AW'(i), '1, $urandom);
      drive2(1'b1, 1'b0, 1'b1, AW'(i + DEPTH / 2), '1, $urandom);
      tick();
    end
    idle();
  endtask

  task automatic test_readback();
    for (int i = 0; i < DEPTH + LAT; i++) begin
      if (i < DEPTH) begin
        drive1(1'b1, 1'b1, 1'b0, AW'(i), '0, '0);
        drive2(1'b1, 1'b1, 1'b0, AW'(DEPTH - 1 - i), '0, '0);
      end else idle();
      tick();
      n_tests++; if ({s1_readdatavalid, s1_readdata} !== {exp_vld1, exp_rd1}) begin n_fail++;
        $display("FAIL readback_s1 step %0d: got %b/%h, expected %b/%h", i, s1_readdatavalid, s1_readdata, exp_vld1, exp_rd1); end
      n_tests++; if ({s2_readdatavalid, s2_readdata} !== {exp_vld2, exp_rd2}) begin n_fail++;
        $display("FAIL readback_s2 step %0d: got %b/%h, expected %b/%h", i, s2_readdatavalid, s2_readdata, exp_vld2, exp_rd2); end
    end
  endtask

  task automatic test_byte_enable();
    drive1(1'b1, 1'b0, 1'b1, AW'(16), '1, 32'h0000_0000); tick();
    drive1(1'b1, 1'b0, 1'b1, AW'(16), 4'b0101, 32'hAABB_CCDD); tick();
    n_tests++; if (s1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL be_write_novalid: got %b, expected 0", s1_readdatavalid); end
    drive1(1'b1, 1'b1, 1'b0, AW'(16), '0, '0); tick();
    idle();
    repeat (LAT - 1) begin
      n_tests++; if (s1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL be_early_valid: got %b, expected 0", s1_readdatavalid); end
      tick();
    end
    n_tests++; if ({s1_readdatavalid, s1_readdata} !== {1'b1, 32'h00BB_00DD}) begin n_fail++;
      $display("FAIL be_read: got %b/%h, expected 1/00bb00dd", s1_readdatavalid, s1_readdata); end
    tick();
    n_tests++; if ({s1_readdatavalid, s1_readdata} !== {1'b0, 32'h00BB_00DD}) begin n_fail++;
      $display("FAIL be_hold: got %b/%h, expected 0/00bb00dd", s1_readdatavalid, s1_readdata); end
  endtask

  task automatic test_cross_port();
    logic [DW-1:0] old [16];
    int nv;
    nv = 0;
    for (int i = 0; i < 16; i++) old[i] = mem_m[i];
    for (int i = 0; i < 16 + LAT; i++) begin
      if (i < 16) drive2(1'b1, 1'b1, 1'b0, AW'(i), '0, '0); else drive2(1'b0, 1'b0, 1'b0, '0, '0, '0);
      if (i == 5) drive1(1'b1, 1'b0, 1'b1, AW'(5), '1, 32'h1234_5678); else drive1(1'b0, 1'b0, 1'b0, '0, '0, '0);
      tick();
      if (s2_readdatavalid === 1'b1) nv++;
      if (i >= LAT - 1 && i - (LAT - 1) < 16) begin
        n_tests++; if ({s2_readdatavalid, s2_readdata} !== {1'b1, old[i - LAT + 1]}) begin n_fail++;
          $display("FAIL cross_stream %0d: got %b/%h, expected 1/%h", i - LAT + 1, s2_readdatavalid, s2_readdata, old[i - LAT + 1]); end
      end
    end
    n_tests++; if (nv !== 16) begin n_fail++; $display("FAIL cross_count: got %0d valids, expected 16", nv); end
    drive2(1'b1, 1'b1, 1'b0, AW'(5), '0, '0); tick();
    idle();
    repeat (LAT - 1) tick();
    n_tests++; if ({s2_readdatavalid, s2_readdata} !== {1'b1, 32'h1234_5678}) begin n_fail++;
      $display("FAIL cross_new: got %b/%h, expected 1/12345678", s2_readdatavalid, s2_readdata); end
  endtask

  task automatic test_collision();
    drive1(1'b1, 1'b0, 1'b1, AW'(32), '1, 32'h1111_1111);
    drive2(1'b1, 1'b0, 1'b1, AW'(32), '1, 32'h2222_2222);
    tick();
    n_tests++; if (collision !== 1'b1) begin n_fail++; $display("FAIL coll_pulse: got %b, expected 1", collision); end
    idle(); tick();
    n_tests++; if (collision !== 1'b0) begin n_fail++; $display("FAIL coll_clear: got %b, expected 0", collision); end
    drive1(1'b1, 1'b1, 1'b0, AW'(32), '0, '0); tick();
    idle();
    repeat (LAT - 1) tick();
    n_tests++; if ({s1_readdatavalid, s1_readdata} !== {1'b1, 32'h1111_1111}) begin n_fail++;
      $display("FAIL coll_data: got %b/%h, expected 1/11111111", s1_readdatavalid, s1_readdata); end
  endtask

  task automatic test_clken_stall();
    logic [DW-1:0] da, db, dc;
    da = mem_m[1]; db = mem_m[2]; dc = mem_m[3];
    clken = 1'b1; idle();
    drive1(1'b1, 1'b1, 1'b0, AW'(1), '0, '0); tick();
    drive1(1'b1, 1'b1, 1'b0, AW'(2), '0, '0); tick();
    n_tests++; if ({s1_readdatavalid, s1_readdata} !== {1'b1, da}) begin n_fail++;
      $display("FAIL stall_first: got %b/%h, expected 1/%h", s1_readdatavalid, s1_readdata, da); end
    clken = 1'b0;
    drive1(1'b1, 1'b1, 1'b0, AW'(3), '0, '0);
    drive2(1'b1, 1'b1, 1'b0, AW'(3), '0, '0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++; if ({s1_waitrequest, s2_waitrequest} !== 2'b11) begin n_fail++;
        $display("FAIL stall_wait %0d: got %b, expected 11", k, {s1_waitrequest, s2_waitrequest}); end
      tick();
      n_tests++; if ({s1_readdatavalid, s1_readdata, s2_readdatavalid} !== {k == 0, db, 1'b0}) begin n_fail++;
        $display("FAIL stall_flight %0d: got %b/%h/%b, expected %b/%h/0", k, s1_readdatavalid, s1_readdata, s2_readdatavalid, k == 0, db); end
    end
    clken = 1'b1; #1;
    n_tests++; if ({s1_waitrequest, s2_waitrequest} !== 2'b00) begin n_fail++;
      $display("FAIL stall_release: got %b, expected 00", {s1_waitrequest, s2_waitrequest}); end
    tick();
    idle(); tick();
    n_tests++; if ({s1_readdatavalid, s1_readdata, s2_readdatavalid, s2_readdata} !== {1'b1, dc, 1'b1, dc}) begin n_fail++;
      $display("FAIL stall_held: got %b/%h %b/%h, expected 1/%h", s1_readdatavalid, s1_readdata, s2_readdatavalid, s2_readdata, dc); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    drive1(1'b1, 1'b1, 1'b0, AW'(7), '0, '0); tick();
    idle(); reset = 1'b1; #1;
    n_tests++; if ({s1_readdatavalid, s2_readdatavalid, collision, s1_readdata, s2_readdata} !== '0) begin n_fail++;
      $display("FAIL midread_outputs: got %b%b%b %h %h, expected all 0", s1_readdatavalid, s2_readdatavalid, collision, s1_readdata, s2_readdata); end
    n_tests++; if (s1_waitrequest !== WAIT_RST) begin n_fail++; $display("FAIL midread_wait: got %b, expected %b", s1_waitrequest, WAIT_RST); end
    tick();
    n_tests++; if (s1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL midread_valid: got %b, expected 0", s1_readdatavalid); end
    reset = 1'b0;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      n_tests++; if (s1_readdatavalid !== 1'b0) begin n_fail++; $display("FAIL midread_late %0d: got %b, expected 0", k, s1_readdatavalid); end
    end
    n = 0;
    while (clearing_m && n < DEPTH + 8) begin n++; tick(); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      clken = ($urandom_range(0, 7) != 0);
      drive1(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom), NB'($urandom), $urandom);
      drive2(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom), NB'($urandom), $urandom);
      #1;
      n_tests++; if ({s1_waitrequest, s2_waitrequest} !== {2{!clken || clearing_m}}) begin n_fail++;
        $display("FAIL rand_wait %0d: got %b, expected %b", c, {s1_waitrequest, s2_waitrequest}, {2{!clken || clearing_m}}); end
      tick();
      n_tests++; if ({s1_readdatavalid, s1_readdata} !== {exp_vld1, exp_rd1}) begin n_fail++;
        $display("FAIL rand_s1 %0d: got %b/%h, expected %b/%h", c, s1_readdatavalid, s1_readdata, exp_vld1, exp_rd1); end
      n_tests++; if ({s2_readdatavalid, s2_readdata} !== {exp_vld2, exp_rd2}) begin n_fail++;
        $display("FAIL rand_s2 %0d: got %b/%h, expected %b/%h", c, s2_readdatavalid, s2_readdata, exp_vld2, exp_rd2); end
      n_tests++; if (collision !== exp_coll) begin n_fail++;
        $display("FAIL rand_coll %0d: got %b, expected %b", c, collision, exp_coll); end
    end
    clken = 1'b1; idle();
    repeat (LAT + 1) tick();
    test_readback();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: no finish by time %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0; n_fail = 0; edge_n = 0; clr_m = 0; clearing_m = 1'b0;
    exp_vld1 = 1'b0; exp_vld2 = 1'b0; exp_rd1 = '0; exp_rd2 = '0; exp_coll = 1'b0;
    reset = 1'b0; clken = 1'b1;
    idle();
    #1 reset = 1'b1;
    test_reset();
`ifdef ONCHIP_RAM_CLEAR_EN
    test_readback();
`endif
    test_fill();
    test_readback();
    test_byte_enable();
    test_cross_port();
    test_collision();
    test_clken_stall();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
